// File: rtl/demux_pkg.sv
// Shared definitions for the 4-channel serial deserializer: channel count,
// default word width, per-channel state encoding and channel-select type.
package demux_pkg;
  localparam int NUM_CH     = 4;
  localparam int WORD_W_DEF = 8;

  typedef enum logic {COLLECT = 1'b0, FULL = 1'b1} deser_st_e;
  typedef logic [1:0] ch_sel_t;

  function automatic logic [NUM_CH-1:0] sel_onehot(input ch_sel_t s);
    return (NUM_CH)'(1) << s;
  endfunction
endpackage

// File: rtl/chan_deser4_chan.sv
// One deserializer channel (module chan_deser): LSB-first collect into a
// shift register, hold the word until consumed. Parity frames under DESER_PARITY_EN.
module chan_deser
  import demux_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic              din,
  input  logic              word_ready,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  output logic              par_err
);
`ifdef DESER_PARITY_EN
  localparam int FRAME = WORD_W + 1;
`else
  localparam int FRAME = WORD_W;
`endif
  localparam int CNT_W = $clog2(FRAME + 1);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(FRAME - 1);
  localparam logic [CNT_W-1:0] DATA_N = CNT_W'(WORD_W);

  deser_st_e        st;
  logic [CNT_W-1:0] cnt;
  logic [WORD_W-1:0] sr;
  logic             done, take, last;

  assign done = (st == FULL) & word_ready;
  // A bit arriving on the handshake cycle starts the next word (cnt is 0 in FULL).
  assign take = bit_en & ((st == COLLECT) | word_ready);
  assign last = take & (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= COLLECT;
      cnt <= '0;
      sr  <= '0;
    end else begin
      if (done) st <= COLLECT;
      if (take) begin
        if (cnt < DATA_N) sr <= {din, sr[WORD_W-1:1]};
        if (last) begin
          st  <= FULL;
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  assign word       = sr;
  assign word_valid = (st == FULL);

`ifdef DESER_PARITY_EN
  logic par;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par     <= 1'b0;
      par_err <= 1'b0;
    end else begin
      if (done) par_err <= 1'b0;
      if (take) begin
        if (last) begin
          par_err <= par ^ din;
          par     <= 1'b0;
        end else begin
          par <= par ^ din;
        end
      end
    end
  end
`else
  assign par_err = 1'b0;
`endif
endmodule

// File: rtl/chan_deser4.sv
// 1:4 serial deserializer: decodes sel onto four chan_deser instances and
// muxes back the selected channel's ready. Parity option: DESER_PARITY_EN.
module chan_deser4
  import demux_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int NUM_CH = demux_pkg::NUM_CH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  din,
  input  logic [1:0]            sel,
  output logic                  in_ready,
  output logic [4*WORD_W-1:0]   word,
  output logic [3:0]            word_valid,
  input  logic [3:0]            word_ready,
  output logic [3:0]            par_err
);
  logic [NUM_CH-1:0][WORD_W-1:0] wd;
  logic [NUM_CH-1:0]             bit_en;

  assign in_ready = ~word_valid[sel] | word_ready[sel];
  assign bit_en   = {NUM_CH{in_valid & in_ready}} & sel_onehot(sel);
  assign word     = wd;

  chan_deser #(.WORD_W(WORD_W)) u_ch [NUM_CH-1:0] (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_en     (bit_en),
    .din        (din),
    .word_ready (word_ready),
    .word       (wd),
    .word_valid (word_valid),
    .par_err    (par_err)
  );
endmodule

// File: tb/tb_chan_deser4.sv
// Directed bench for chan_deser4: table of single-channel words plus
// interleave, backpressure, reset mid-frame, idle and parity sequences.
module tb_chan_deser4;
  localparam int W = 8;
`ifdef DESER_PARITY_EN
  localparam int FR = W + 1;
`else
  localparam int FR = W;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        din = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic        in_ready;
  logic [4*W-1:0] word;
  logic [3:0]  word_valid;
  logic [3:0]  word_ready = 4'b0;
  logic [3:0]  par_err;

  int n_cmp = 0;
  int n_bad = 0;

  chan_deser4 #(.WORD_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .din(din), .sel(sel),
    .in_ready(in_ready), .word(word), .word_valid(word_valid),
    .word_ready(word_ready), .par_err(par_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] data;
    logic [3:0] exp_vld;
    logic [7:0] exp_word;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Bit k of a frame; the trailing bit (parity builds) is even parity.
  function automatic logic fbit(input logic [7:0] d, input int k);
    logic [7:0] t;
    t = d;
    if (k < W) return t[k];
    return ^t;
  endfunction

  task automatic send_bit(input logic [1:0] ch, input logic b);
    in_valid = 1'b1; sel = ch; din = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic consume(input int ch);
    word_ready[ch] = 1'b1;
    @(posedge clk); #1;
    word_ready[ch] = 1'b0;
  endtask

  vec_t vt[5];

  initial begin
    vt[0] = '{2'd2, 8'hA5, 4'b0100, 8'hA5};
    vt[1] = '{2'd0, 8'h3C, 4'b0001, 8'h3C};
    vt[2] = '{2'd1, 8'hFF, 4'b0010, 8'hFF};
    vt[3] = '{2'd3, 8'h00, 4'b1000, 8'h00};
    vt[4] = '{2'd0, 8'h81, 4'b0001, 8'h81};

    #2;
    chk("reset word_valid", {28'd0, word_valid}, 0);
    chk("reset word", word, 0);
    chk("reset par_err", {28'd0, par_err}, 0);
    chk("reset in_ready", {31'd0, in_ready}, 1);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < FR; k++) begin
        send_bit(vt[i].sel, fbit(vt[i].data, k));
        if (k == FR - 2) chk($sformatf("vec%0d early valid", i), {28'd0, word_valid}, 0);
      end
      chk($sformatf("vec%0d word_valid", i), {28'd0, word_valid}, {28'd0, vt[i].exp_vld});
      chk($sformatf("vec%0d word", i), {24'd0, word[vt[i].sel*W +: W]}, {24'd0, vt[i].exp_word});
      chk($sformatf("vec%0d par_err", i), {28'd0, par_err}, 0);
      consume(vt[i].sel);
      chk($sformatf("vec%0d consumed", i), {28'd0, word_valid}, 0);
    end

    // interleave ch0 (0x3C) and ch3 (0xC3) each cycle
    for (int k = 0; k < FR; k++) begin
      send_bit(2'd0, fbit(8'h3C, k));
      if (k == FR - 1) chk("ilv ch0 first", {28'd0, word_valid}, 32'h1);
      send_bit(2'd3, fbit(8'hC3, k));
    end
    chk("ilv both valid", {28'd0, word_valid}, 32'h9);
    chk("ilv ch0 word", {24'd0, word[7:0]}, 32'h3C);
    chk("ilv ch3 word", {24'd0, word[31:24]}, 32'hC3);
    consume(0);
    consume(3);

    // backpressure on ch1
    for (int k = 0; k < FR; k++) send_bit(2'd1, fbit(8'h5A, k));
    in_valid = 1'b1; sel = 2'd1; din = 1'b1; #1;
    chk("bp in_ready low", {31'd0, in_ready}, 0);
    @(posedge clk); #1;
    chk("bp word held", {24'd0, word[15:8]}, 32'h5A);
    chk("bp valid held", {28'd0, word_valid}, 32'h2);
    word_ready[1] = 1'b1; #1;
    chk("bp in_ready high", {31'd0, in_ready}, 1);
    @(posedge clk); #1;
    word_ready[1] = 1'b0; in_valid = 1'b0;
    chk("bp handshake", {28'd0, word_valid}, 0);
    for (int k = 1; k < FR; k++) send_bit(2'd1, fbit(8'h03, k));
    chk("bp next valid", {28'd0, word_valid}, 32'h2);
    chk("bp next word", {24'd0, word[15:8]}, 32'h03);
    consume(1);

    // reset mid-frame, with ch2 holding a word
    for (int k = 0; k < FR; k++) send_bit(2'd2, fbit(8'h77, k));
    for (int k = 0; k < 5; k++) send_bit(2'd0, 1'b1);
    #2; rst_n = 1'b0; #1;
    chk("rst async valid", {28'd0, word_valid}, 0);
    chk("rst async word", word, 0);
    #2; rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < FR; k++) send_bit(2'd0, fbit(8'h96, k));
    chk("rst clean valid", {28'd0, word_valid}, 32'h1);
    chk("rst clean word", {24'd0, word[7:0]}, 32'h96);
    consume(0);

    // idle with din toggling mid-frame on ch3
    for (int k = 0; k < 3; k++) send_bit(2'd3, fbit(8'h6D, k));
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b0; din = c[0]; sel = c[1:0];
      @(posedge clk); #1;
    end
    chk("idle valid", {28'd0, word_valid}, 0);
    for (int k = 3; k < FR; k++) send_bit(2'd3, fbit(8'h6D, k));
    chk("idle resume valid", {28'd0, word_valid}, 32'h8);
    chk("idle resume word", {24'd0, word[31:24]}, 32'h6D);
    consume(3);

`ifdef DESER_PARITY_EN
    for (int k = 0; k < W; k++) send_bit(2'd0, fbit(8'h01, k));
    send_bit(2'd0, 1'b1);
    chk("par good valid", {28'd0, word_valid}, 32'h1);
    chk("par good err", {28'd0, par_err}, 0);
    consume(0);
    for (int k = 0; k < W; k++) send_bit(2'd0, fbit(8'h01, k));
    send_bit(2'd0, 1'b0);
    chk("par bad valid", {28'd0, word_valid}, 32'h1);
    chk("par bad err", {28'd0, par_err}, 32'h1);
    chk("par bad word", {24'd0, word[7:0]}, 32'h01);
    consume(0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
